// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared types and constants for the JPEG word packer.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

  localparam int BEAT_BYTES  = 16;
  localparam int WORD_BYTES  = 4;
  // A beat is only taken with at most 3 bytes resident, so 19 bytes suffice.
  localparam int STAGE_BYTES = BEAT_BYTES + WORD_BYTES - 1;
  localparam int COUNT_W     = 5;

  typedef logic [19:0] size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/jpeg_byte_stager.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_byte_stager
// Description : 19-byte staging register; appends beats behind resident
//               bytes and retires the lowest 32-bit word on request.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_byte_stager
  import jpeg_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_shift,
  input  logic                      i_drop,
  input  logic                      i_append,
  input  logic [BEAT_BYTES*8-1:0]   i_data,
  input  logic [COUNT_W-1:0]        i_bytes,
  output logic [COUNT_W-1:0]        o_count,
  output logic [WORD_BYTES*8-1:0]   o_word
);

  localparam int c_STAGE_W = STAGE_BYTES * 8;
  localparam int c_PAD_W   = c_STAGE_W - BEAT_BYTES * 8;

  logic [c_STAGE_W-1:0]    r_stage;
  logic [COUNT_W-1:0]      r_count;
  logic [BEAT_BYTES*8-1:0] w_masked;
  logic [c_STAGE_W-1:0]    w_appended;

  // Bytes beyond the valid count are zeroed so the stage above count stays
  // clear; that is what makes the final short word come out zero-padded.
  always_comb begin
    w_masked = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if (COUNT_W'(k) < i_bytes) begin
        w_masked[8*k +: 8] = i_data[8*k +: 8];
      end
    end
  end

  assign w_appended = r_stage | ({{c_PAD_W{1'b0}}, w_masked} << {r_count, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
      r_count <= '0;
    end else if (i_clear || i_drop) begin
      r_stage <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_stage <= r_stage >> (WORD_BYTES * 8);
      r_count <= r_count - COUNT_W'(WORD_BYTES);
    end else if (i_append) begin
      r_stage <= w_appended;
      r_count <= r_count + i_bytes;
    end
  end

  assign o_count = r_count;
  assign o_word  = r_stage[WORD_BYTES*8-1:0];

endmodule
`default_nettype wire

// File: rtl/jpeg_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_word_packer
// Description : Packs variable-length encoder beats into 32-bit buffer words.
//               Define JPEG_WORD_PACKER_BIG_ENDIAN_EN for big-endian words.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_word_packer
  import jpeg_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
)
(
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    clear_in,
  input  logic [BEAT_BYTES*8-1:0] in_data,
  input  logic [4:0]              in_bytes,
  input  logic                    in_valid,
  input  logic                    in_tlast,
  output logic                    in_hold,
  output logic [ADDR_WIDTH-1:0]   wr_address,
  output logic [31:0]             wr_data,
  output logic                    wr_enable,
  output logic [19:0]             size_out,
  output logic                    done_out,
  output logic                    overflow_out
);

  localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
  localparam logic [1:0] c_ST_RUN   = ST_RUN;
  localparam logic [1:0] c_ST_FLUSH = ST_FLUSH;
  localparam logic [1:0] c_ST_DONE  = ST_DONE;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [COUNT_W-1:0]    c_WORD_CNT = COUNT_W'(WORD_BYTES);
  localparam logic [COUNT_W-1:0]    c_BEAT_CNT = COUNT_W'(BEAT_BYTES);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_addr_full;
  size_t                 r_size;
  logic                  r_done;
  logic                  r_overflow;

  logic [COUNT_W-1:0]    w_count;
  logic [31:0]           w_low_word;
  logic [31:0]           w_ordered;
  logic [COUNT_W-1:0]    w_bytes;
  logic                  w_emit_full;
  logic                  w_emit_pad;
  logic                  w_emit;
  logic                  w_write;
  logic                  w_accept;

  assign w_bytes     = (in_bytes > c_BEAT_CNT) ? c_BEAT_CNT : in_bytes;
  assign w_emit_full = (w_count >= c_WORD_CNT);
  assign w_emit_pad  = (r_state == c_ST_FLUSH) && (w_count != '0) && !w_emit_full;
  assign w_emit      = (w_emit_full || w_emit_pad) && !clear_in;
  assign w_write     = w_emit && !r_addr_full;

  // FLUSH also holds off the source: the padded word must never share a
  // cycle with an accept, and a new frame only starts after clear.
  assign in_hold  = clear_in || r_done || w_emit_full ||
                    (r_state == c_ST_FLUSH) || (r_state == c_ST_DONE);
  assign w_accept = in_valid && !in_hold;

  jpeg_byte_stager u_stager (
    .clk      (clock_in),
    .rst      (reset_in),
    .i_clear  (clear_in),
    .i_shift  (w_emit_full && !clear_in),
    .i_drop   (w_emit_pad && !clear_in),
    .i_append (w_accept),
    .i_data   (in_data),
    .i_bytes  (w_bytes),
    .o_count  (w_count),
    .o_word   (w_low_word)
  );

`ifdef JPEG_WORD_PACKER_BIG_ENDIAN_EN
  assign w_ordered = {w_low_word[7:0], w_low_word[15:8],
                      w_low_word[23:16], w_low_word[31:24]};
`else
  assign w_ordered = w_low_word;
`endif

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= c_ST_IDLE;
      r_addr      <= '0;
      r_addr_full <= 1'b0;
      r_size      <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clear_in) begin
      r_state     <= c_ST_IDLE;
      r_addr      <= '0;
      r_addr_full <= 1'b0;
      r_size      <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_size <= r_size + size_t'(w_bytes);
      end
      // The address parks on the last word instead of wrapping.
      if (w_write) begin
        if (r_addr == c_ADDR_MAX) begin
          r_addr_full <= 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
      if (w_emit && r_addr_full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        c_ST_IDLE, c_ST_RUN: begin
          if (w_accept) begin
            r_state <= in_tlast ? c_ST_FLUSH : c_ST_RUN;
          end
        end
        c_ST_FLUSH: begin
          if (w_count == '0) begin
            r_state <= c_ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wr_enable    = w_write;
  assign wr_address   = r_addr;
  assign wr_data      = w_write ? w_ordered : 32'h0;
  assign size_out     = r_size;
  assign done_out     = r_done;
  assign overflow_out = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_word_packer
// Description : Self-checking bench for jpeg_word_packer (default buffer and
//               a 16-word buffer driven in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_word_packer;

  logic         clock_in = 1'b0;
  logic         reset_in;
  logic         clear_in;
  logic [127:0] in_data;
  logic [4:0]   in_bytes;
  logic         in_valid;
  logic         in_tlast;

  logic         hold_b, en_b, done_b, ovf_b;
  logic [13:0]  addr_b;
  logic [31:0]  data_b;
  logic [19:0]  size_b;
  logic         hold_s, en_s, done_s, ovf_s;
  logic [3:0]   addr_s;
  logic [31:0]  data_s;
  logic [19:0]  size_s;

  always #5 clock_in = ~clock_in;

  jpeg_word_packer dut_big (
    .clock_in(clock_in), .reset_in(reset_in), .clear_in(clear_in),
    .in_data(in_data), .in_bytes(in_bytes), .in_valid(in_valid), .in_tlast(in_tlast),
    .in_hold(hold_b), .wr_address(addr_b), .wr_data(data_b), .wr_enable(en_b),
    .size_out(size_b), .done_out(done_b), .overflow_out(ovf_b)
  );

  jpeg_word_packer #(.ADDR_WIDTH(4)) dut_small (
    .clock_in(clock_in), .reset_in(reset_in), .clear_in(clear_in),
    .in_data(in_data), .in_bytes(in_bytes), .in_valid(in_valid), .in_tlast(in_tlast),
    .in_hold(hold_s), .wr_address(addr_s), .wr_data(data_s), .wr_enable(en_s),
    .size_out(size_s), .done_out(done_s), .overflow_out(ovf_s)
  );

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t  wq_b[$];
  wr_t  wq_s[$];
  int   beat_len[$];
  logic [7:0] beat_bytes[$];
  longint acc_t[$];

  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clock_in) begin
    if (en_b === 1'b1) wq_b.push_back('{int'(addr_b), data_b});
    if (en_s === 1'b1) wq_s.push_back('{int'(addr_s), data_s});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Stream byte 0 goes to the low lane unless big-endian words are built.
  function automatic logic [31:0] order(input logic [31:0] le);
`ifdef JPEG_WORD_PACKER_BIG_ENDIAN_EN
    return {le[7:0], le[15:8], le[23:16], le[31:24]};
`else
    return le;
`endif
  endfunction

  function automatic logic [31:0] model_word(input int i);
    logic [31:0] le = '0;
    for (int k = 0; k < 4; k++) begin
      if (4*i + k < beat_bytes.size()) le[8*k +: 8] = beat_bytes[4*i + k];
    end
    return order(le);
  endfunction

  task automatic pulse_clear();
    clear_in = 1'b1;
    @(posedge clock_in); #1;
    clear_in = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input int n, input bit last);
    int g = 0;
    in_data = d; in_bytes = 5'(n); in_tlast = last; in_valid = 1'b1;
    @(negedge clock_in);
    while (hold_b !== 1'b0 && g < 200) begin
      @(negedge clock_in);
      g++;
    end
    if (hold_b !== 1'b0) chk("accept_timeout", 32'(hold_b), 0);
    @(posedge clock_in);
    acc_t.push_back($time);
    #1;
    in_valid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    @(negedge clock_in);
    while (done_b !== 1'b1 && g < 400) begin
      @(negedge clock_in);
      g++;
    end
    chk("done_out", 32'(done_b), 1);
    @(posedge clock_in); #1;
  endtask

  // Drives the current beat_len/beat_bytes frame; unused lanes carry junk.
  task automatic run_frame(input bit gaps);
    int pos = 0;
    logic [127:0] d;
    wq_b.delete(); wq_s.delete(); acc_t.delete();
    pulse_clear();
    for (int b = 0; b < beat_len.size(); b++) begin
      for (int k = 0; k < 16; k++) begin
        if (k < beat_len[b]) d[8*k +: 8] = beat_bytes[pos + k];
        else                 d[8*k +: 8] = 8'($urandom);
      end
      pos += beat_len[b];
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clock_in); #1; end
      end
      send_beat(d, beat_len[b], b == beat_len.size() - 1);
    end
    wait_done();
  endtask

  task automatic verify();
    int nb = beat_bytes.size();
    int nw = (nb + 3) / 4;
    int ns = (nw > 16) ? 16 : nw;
    chk("size_big", 32'(size_b), 32'(nb));
    chk("size_small", 32'(size_s), 32'(nb));
    chk("ovf_big", 32'(ovf_b), 0);
    chk("ovf_small", 32'(ovf_s), 32'(nw > 16));
    chk("done_small", 32'(done_s), 1);
    chk("nwr_big", 32'(wq_b.size()), 32'(nw));
    chk("nwr_small", 32'(wq_s.size()), 32'(ns));
    chk("addr_end_big", 32'(addr_b), 32'(nw));
    chk("addr_end_small", 32'(addr_s), 32'((nw >= 16) ? 15 : nw));
    for (int i = 0; i < wq_b.size() && i < nw; i++) begin
      chk("addr_big", 32'(wq_b[i].addr), 32'(i));
      chk("word_big", wq_b[i].data, model_word(i));
    end
    for (int i = 0; i < wq_s.size() && i < ns; i++) begin
      chk("addr_small", 32'(wq_s[i].addr), 32'(i));
      chk("word_small", wq_s[i].data, model_word(i));
    end
  endtask

  typedef struct {
    int          nb;
    int          len[5];
    logic [7:0]  start;
    int          exp_size;
    int          exp_words;
    logic [31:0] w0;
    logic [31:0] wl;
    bit          ovf_s;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    logic [127:0] d;
    int nbt, l;

    tbl[0] = '{1, '{16, 0, 0, 0, 0}, 8'h00, 16,  4, 32'h03020100, 32'h0F0E0D0C, 1'b0};
    tbl[1] = '{3, '{5, 7, 3, 0, 0},  8'h10, 15,  4, 32'h13121110, 32'h001E1D1C, 1'b0};
    tbl[2] = '{3, '{4, 0, 4, 0, 0},  8'h40,  8,  2, 32'h43424140, 32'h47464544, 1'b0};
    tbl[3] = '{1, '{0, 0, 0, 0, 0},  8'h00,  0,  0, 32'h0,        32'h0,        1'b0};
    tbl[4] = '{5, '{16, 16, 16, 16, 8}, 8'h80, 72, 18, 32'h83828180, 32'hC7C6C5C4, 1'b1};
    tbl[5] = '{1, '{1, 0, 0, 0, 0},  8'hAA,  1,  1, 32'h000000AA, 32'h000000AA, 1'b0};

    reset_in = 1'b1; clear_in = 1'b0; in_valid = 1'b0; in_tlast = 1'b0;
    in_data = '0; in_bytes = '0;

    // Reset state
    @(negedge clock_in);
    chk("rst_hold", 32'(hold_b), 0);
    chk("rst_addr", 32'(addr_b), 0);
    chk("rst_data", data_b, 0);
    chk("rst_wren", 32'(en_b), 0);
    chk("rst_size", 32'(size_b), 0);
    chk("rst_done", 32'(done_b), 0);
    chk("rst_ovf", 32'(ovf_b), 0);
    @(negedge clock_in);
    reset_in = 1'b0;
    @(posedge clock_in); #1;

    // One 16-byte tlast beat: writes on the four cycles after acceptance
    pulse_clear();
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
    send_beat(d, 16, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_in);
      chk("lat_wren", 32'(en_b), 1);
      chk("lat_hold", 32'(hold_b), 1);
      chk("lat_addr", 32'(addr_b), 32'(i));
      chk("lat_word", data_b, order({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}));
    end
    @(negedge clock_in);
    chk("lat_idle_wren", 32'(en_b), 0);
    chk("lat_done_early", 32'(done_b), 0);
    @(negedge clock_in);
    chk("lat_done", 32'(done_b), 1);
    chk("lat_size", 32'(size_b), 16);
    @(posedge clock_in); #1;

    // Table-driven frames
    for (int t = 0; t < 6; t++) begin
      beat_len.delete(); beat_bytes.delete();
      for (int b = 0; b < tbl[t].nb; b++) beat_len.push_back(tbl[t].len[b]);
      for (int k = 0; k < tbl[t].exp_size; k++) beat_bytes.push_back(tbl[t].start + 8'(k));
      run_frame(1'b0);
      verify();
      chk("tbl_size", 32'(size_b), 32'(tbl[t].exp_size));
      chk("tbl_nwr", 32'(wq_b.size()), 32'(tbl[t].exp_words));
      chk("tbl_ovf_small", 32'(ovf_s), 32'(tbl[t].ovf_s));
      if (tbl[t].exp_words > 0 && wq_b.size() > 0) begin
        chk("tbl_word0", wq_b[0].data, order(tbl[t].w0));
        chk("tbl_wordl", wq_b[wq_b.size()-1].data, order(tbl[t].wl));
      end
    end

    // Back-to-back 16-byte beats: one accept every five cycles
    beat_len.delete(); beat_bytes.delete();
    for (int b = 0; b < 6; b++) begin
      beat_len.push_back(16);
      repeat (16) beat_bytes.push_back(8'($urandom));
    end
    run_frame(1'b0);
    verify();
    for (int i = 1; i < acc_t.size(); i++)
      chk("accept_gap", 32'((acc_t[i] - acc_t[i-1]) / 10), 5);

    // Clear while DONE with a beat offered (small buffer has overflowed)
    d = {4{$urandom}};
    in_data = d; in_bytes = 5'd16; in_valid = 1'b1; in_tlast = 1'b0; clear_in = 1'b1;
    @(negedge clock_in);
    chk("clr_hold", 32'(hold_b), 1);
    chk("clr_wren", 32'(en_b), 0);
    chk("clr_ovf_before", 32'(ovf_s), 1);
    @(posedge clock_in); #1;
    clear_in = 1'b0; in_valid = 1'b0;
    @(negedge clock_in);
    chk("clr_size", 32'(size_b), 0);
    chk("clr_done", 32'(done_b), 0);
    chk("clr_ovf", 32'(ovf_s), 0);
    chk("clr_addr", 32'(addr_b), 0);
    @(posedge clock_in); #1;

    // Clear mid-frame with 7 bytes staged and a beat offered
    wq_b.delete();
    send_beat(d, 7, 1'b0);
    clear_in = 1'b1; in_valid = 1'b1; in_bytes = 5'd16;
    @(negedge clock_in);
    chk("mid_clr_wren", 32'(en_b), 0);
    chk("mid_clr_hold", 32'(hold_b), 1);
    @(posedge clock_in); #1;
    clear_in = 1'b0; in_valid = 1'b0;
    @(negedge clock_in);
    chk("mid_clr_size", 32'(size_b), 0);
    chk("mid_clr_stage", 32'(en_b), 0);
    chk("mid_clr_hold_after", 32'(hold_b), 0);
    @(posedge clock_in); #1;
    chk("mid_clr_nwr", 32'(wq_b.size()), 0);

    // Reset during FLUSH with two bytes left: no padded write
    pulse_clear();
    wq_b.delete();
    send_beat(d, 6, 1'b1);
    @(negedge clock_in);
    #1 reset_in = 1'b1;
    #1;
    chk("frst_hold", 32'(hold_b), 0);
    chk("frst_addr", 32'(addr_b), 0);
    chk("frst_data", data_b, 0);
    chk("frst_wren", 32'(en_b), 0);
    chk("frst_size", 32'(size_b), 0);
    chk("frst_done", 32'(done_b), 0);
    chk("frst_ovf", 32'(ovf_b), 0);
    @(posedge clock_in); #1;
    @(negedge clock_in); #1;
    reset_in = 1'b0;
    repeat (4) @(posedge clock_in);
    #1;
    chk("frst_nwr", 32'(wq_b.size()), 1);

    // Randomised frames against the packing model
    for (int f = 0; f < 25; f++) begin
      beat_len.delete(); beat_bytes.delete();
      nbt = $urandom_range(1, 5);
      for (int b = 0; b < nbt; b++) begin
        l = $urandom_range(0, 16);
        beat_len.push_back(l);
        repeat (l) beat_bytes.push_back(8'($urandom));
      end
      run_frame(1'b1);
      verify();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
